// File: rtl/sdivmod_pkg.sv
// Shared definitions for the signed divide/modulo reconstruction datapath.
package sdivmod_pkg;

  localparam int unsigned DATAWIDTH_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ADD  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Width of a counter that holds 0..n-1 (at least one bit).
  function automatic int unsigned clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_umul.sv
// Unsigned shift-add multiplier: one multiplier bit per step, LSB first.
module seq_umul
  import sdivmod_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DATAWIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     step,
  input  logic [DATAWIDTH-1:0]     mcand_i,
  input  logic [DATAWIDTH-1:0]     mplier_i,
  output logic [2*DATAWIDTH-1:0]   prod_o,
  output logic                     last_c
);

  localparam int unsigned PW = 2 * DATAWIDTH;
  localparam int unsigned CW = clog2(DATAWIDTH);

  logic [PW-1:0]        acc_q,    acc_d;
  logic [PW-1:0]        mcand_q,  mcand_d;
  logic [DATAWIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q,    cnt_d;

  // Load clears the accumulator; each step adds the shifted multiplicand when the current bit is set.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load) begin
      acc_d    = '0;
      mcand_d  = PW'(mcand_i);
      mplier_d = mplier_i;
      cnt_d    = '0;
    end else if (step) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign prod_o = acc_q;
  assign last_c = (cnt_q == CW'(DATAWIDTH - 1));

endmodule

// File: rtl/sdivmod_recon.sv
// Rebuilds the dividend a = q*b + r from a truncating signed divide result and
// flags overflow and inconsistent (q, b, r) triples.
module sdivmod_recon
  import sdivmod_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DATAWIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] q,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [DATAWIDTH-1:0] r,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] a,
  output logic                 ovf,
  output logic                 err
);

  localparam int unsigned W  = DATAWIDTH;
  localparam int unsigned SW = 2 * DATAWIDTH + 1;

  state_e         state_q, state_d;
  logic           sign_q,  sign_d;
  logic [W-1:0]   r_q,     r_d;
  logic [W-1:0]   b_abs_q, b_abs_d;
  logic           busy_q,  busy_d;
  logic           done_q,  done_d;
  logic [W-1:0]   a_q,     a_d;
  logic           ovf_q,   ovf_d;
  logic           err_q,   err_d;

  logic           mul_load, mul_step, mul_last;
  logic [2*W-1:0] prod;
  logic [W-1:0]   q_abs, b_abs, r_abs;
  logic [SW-1:0]  prod_ext, prod_sgn, r_ext, sum;
  logic           fits, bad_triple;

  // Magnitudes; the most-negative value maps to 2^(W-1), which fits unsigned W bits.
  always_comb begin
    q_abs = q[W-1]   ? W'(-q)   : q;
    b_abs = b[W-1]   ? W'(-b)   : b;
    r_abs = r_q[W-1] ? W'(-r_q) : r_q;
  end

  seq_umul #(.DATAWIDTH(W)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .load     (mul_load),
    .step     (mul_step),
    .mcand_i  (q_abs),
    .mplier_i (b_abs),
    .prod_o   (prod),
    .last_c   (mul_last)
  );

  // Signed product plus sign-extended remainder, with range and consistency checks.
  always_comb begin
    prod_ext   = {1'b0, prod};
    prod_sgn   = sign_q ? SW'(-prod_ext) : prod_ext;
    r_ext      = {{(W + 1){r_q[W-1]}}, r_q};
    sum        = prod_sgn + r_ext;
    fits       = (sum[SW-1:W-1] == {(W + 2){sum[W-1]}});
    bad_triple = (b_abs_q == '0) ||
                 (r_abs >= b_abs_q) ||
                 ((r_q != '0) && (r_q[W-1] != sum[SW-1]));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    r_d      = r_q;
    b_abs_d  = b_abs_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    a_d      = a_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    mul_load = 1'b0;
    mul_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mul_load = 1'b1;
          sign_d   = q[W-1] ^ b[W-1];
          r_d      = r;
          b_abs_d  = b_abs;
          busy_d   = 1'b1;
          state_d  = ST_MUL;
        end
      end
      ST_MUL: begin
        mul_step = 1'b1;
        if (mul_last) begin
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        a_d     = sum[W-1:0];
        ovf_d   = !fits;
        err_d   = bad_triple;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
      r_q     <= '0;
      b_abs_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      r_q     <= r_d;
      b_abs_q <= b_abs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      a_q     <= a_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign a    = a_q;
  assign ovf  = ovf_q;
  assign err  = err_q;

endmodule

// File: tb/tb_sdivmod_recon.sv
// Directed bench for sdivmod_recon at DATAWIDTH=8 plus random W=64 reconstruction.
module tb_sdivmod_recon;

  logic clk = 1'b0;
  logic rst;

  logic       start8;
  logic [7:0] q8, b8, r8, a8;
  logic       busy8, done8, ovf8, err8;

  logic        start64;
  logic [63:0] q64, b64, r64, a64;
  logic        busy64, done64, ovf64, err64;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sdivmod_recon #(.DATAWIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .q(q8), .b(b8), .r(r8),
    .busy(busy8), .done(done8), .a(a8), .ovf(ovf8), .err(err8)
  );

  sdivmod_recon #(.DATAWIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .start(start64), .q(q64), .b(b64), .r(r64),
    .busy(busy64), .done(done64), .a(a64), .ovf(ovf64), .err(err64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One W=8 operation; optionally pulses start (with junk operands) during MUL.
  task automatic run8(input logic [7:0] qi, input logic [7:0] bi, input logic [7:0] ri,
                      input logic [7:0] ea, input logic eo, input logic ee,
                      input bit poke, input string tag);
    int n;
    bit seen;
    tick();
    q8 = qi; b8 = bi; r8 = ri; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    q8 = 8'hA5; b8 = 8'h5A; r8 = 8'h3C;
    chk({tag, "_busy_acc"}, 64'(busy8), 64'(1));
    n = 0;
    while (!done8 && n < 40) begin
      start8 = (poke && n == 2);
      if (start8) begin
        q8 = 8'h7F; b8 = 8'h7F; r8 = 8'h01;
      end
      tick();
      n++;
    end
    start8 = 1'b0;
    chk({tag, "_lat"}, 64'(n), 64'(9));
    chk({tag, "_a"}, 64'(a8), 64'(ea));
    chk({tag, "_ovf"}, 64'(ovf8), 64'(eo));
    chk({tag, "_err"}, 64'(err8), 64'(ee));
    chk({tag, "_busy_done"}, 64'(busy8), 64'(1));
    tick();
    chk({tag, "_done_pulse"}, 64'(done8), 64'(0));
    chk({tag, "_busy_idle"}, 64'(busy8), 64'(0));
    chk({tag, "_a_hold"}, 64'(a8), 64'(ea));
    if (poke) begin
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        tick();
        seen |= done8;
      end
      chk({tag, "_no_second_done"}, 64'(seen), 64'(0));
    end
  endtask

  task automatic run64(input logic [63:0] qi, input logic [63:0] bi, input logic [63:0] ri,
                       input logic [63:0] ea, input string tag);
    int n;
    tick();
    q64 = qi; b64 = bi; r64 = ri; start64 = 1'b1;
    tick();
    start64 = 1'b0;
    n = 0;
    while (!done64 && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(65));
    chk({tag, "_a"}, a64, ea);
    chk({tag, "_ovf"}, 64'(ovf64), 64'(0));
    chk({tag, "_err"}, 64'(err64), 64'(0));
  endtask

  initial begin
    logic signed [63:0] av, bv, qv, rv;
    bit seen;
    rst = 1'b1;
    start8 = 1'b0; q8 = '0; b8 = '0; r8 = '0;
    start64 = 1'b0; q64 = '0; b64 = '0; r64 = '0;
    repeat (3) tick();
    chk("rst_busy", 64'(busy8), 64'(0));
    chk("rst_done", 64'(done8), 64'(0));
    chk("rst_a", 64'(a8), 64'(0));
    chk("rst_ovf", 64'(ovf8), 64'(0));
    chk("rst_err", 64'(err8), 64'(0));
    chk("rst_a64", a64, 64'(0));
    rst = 1'b0;

    // -7*3 + -2 = -23
    run8(8'hF9, 8'h03, 8'hFE, 8'hE9, 1'b0, 1'b0, 1'b0, "neg_basic");
    // 20*7 + 6 = 146 overflows
    run8(8'd20, 8'd7, 8'd6, 8'h92, 1'b1, 1'b0, 1'b0, "ovf_pos");
    // |r| >= |b|
    run8(8'd1, 8'd3, 8'd5, 8'd8, 1'b0, 1'b1, 1'b0, "r_too_big");
    // b == 0 passes r through
    run8(8'd4, 8'd0, 8'd9, 8'd9, 1'b0, 1'b1, 1'b0, "b_zero");
    // -128 * -1 = 128 overflows
    run8(8'h80, 8'hFF, 8'h00, 8'h80, 1'b1, 1'b0, 1'b0, "min_neg1");
    // -128 * 1 = -128 fits
    run8(8'h80, 8'h01, 8'h00, 8'h80, 1'b0, 1'b0, 1'b0, "min_pos1");
    // -3*-5 + -4 = 11: remainder sign disagrees with dividend
    run8(8'hFD, 8'hFB, 8'hFC, 8'h0B, 1'b0, 1'b1, 1'b0, "r_sign");
    // 0*5 + 0 = 0
    run8(8'h00, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "zero");
    // 5*-6 + 0 = -30 with start poked during MUL
    run8(8'h05, 8'hFA, 8'h00, 8'hE2, 1'b0, 1'b0, 1'b1, "poke");

    // Reset in the fourth MUL cycle
    tick();
    q8 = 8'd3; b8 = 8'd5; r8 = 8'd1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 64'(busy8), 64'(0));
    chk("midrst_done", 64'(done8), 64'(0));
    chk("midrst_a", 64'(a8), 64'(0));
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      seen |= done8;
    end
    chk("midrst_no_done", 64'(seen), 64'(0));
    run8(8'd3, 8'd5, 8'd1, 8'd16, 1'b0, 1'b0, 1'b0, "post_rst");

    // W=64: operands from the simulator's own truncating divide
    run64(64'hFFFF_FFFF_FFFF_FFFB, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFDA, "d64");
    for (int i = 0; i < 5; i++) begin
      av = $signed({$urandom(), $urandom()});
      bv = $signed({$urandom(), $urandom()}) >>> $urandom_range(0, 62);
      if (bv == 0) bv = 64'sd3;
      if (bv == -64'sd1) bv = -64'sd5;
      qv = av / bv;
      rv = av % bv;
      run64(qv, bv, rv, av, "rand64");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
